// File: rtl/i2s_tx.sv
// I2S (Philips) master transmitter: frame FIFO, BCLK/WS generation and MSB-first
// serialisation of stereo PCM frames, with underrun signalling on empty loads.
module i2s_tx #(
    parameter int unsigned SAMPLE_W   = 16,
    parameter int unsigned SLOT_W     = 32,
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          HCLK,
    input  logic                          HRESETn,
    input  logic                          en,
    input  logic [2*SAMPLE_W-1:0]         s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic                          sck,
    output logic                          ws,
    output logic                          sd,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underrun,
    output logic                          busy
);

    localparam int unsigned FRAME_W = 2 * SLOT_W;
    localparam int unsigned BIT_W   = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned AW      = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W   = AW + 1;
    localparam int unsigned PAD     = SLOT_W - SAMPLE_W;

    localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(FRAME_W - 1);
    localparam logic [BIT_W-1:0] WS_SET_BIT = BIT_W'(SLOT_W - 1);
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [LVL_W-1:0] FULL_LVL   = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t               state, state_nxt;
    logic [DIV_W-1:0]     div_cnt, div_nxt;
    logic [BIT_W-1:0]     bit_cnt, bit_nxt;
    logic [FRAME_W-1:0]   shreg, shreg_nxt;
    logic                 sck_nxt, ws_nxt, sd_nxt, underrun_nxt, busy_nxt;
    logic [AW-1:0]        wr_ptr, wr_nxt, rd_ptr, rd_nxt;
    logic [LVL_W-1:0]     level_nxt;
    logic                 ready_nxt;
    logic                 push, pop;

    logic [2*SAMPLE_W-1:0] mem [FIFO_DEPTH];
    logic [2*SAMPLE_W-1:0] head;
    logic [SLOT_W-1:0]     left_slot, right_slot;
    logic [FRAME_W-1:0]    load_word;
    logic                  tick, fall;

    // FIFO head laid out as the full serial frame: each sample MSB-aligned in its slot
    assign head       = mem[rd_ptr];
    assign left_slot  = SLOT_W'(head[2*SAMPLE_W-1:SAMPLE_W]) << PAD;
    assign right_slot = SLOT_W'(head[SAMPLE_W-1:0]) << PAD;
    assign load_word  = {left_slot, right_slot};

    assign tick = (div_cnt == DIV_LAST);
    assign fall = tick && sck;
    assign push = s_valid && s_ready;

    // Next-state, clocking, serialiser and FIFO bookkeeping
    always_comb begin
        state_nxt    = state;
        div_nxt      = div_cnt;
        bit_nxt      = bit_cnt;
        shreg_nxt    = shreg;
        sck_nxt      = sck;
        ws_nxt       = ws;
        sd_nxt       = sd;
        underrun_nxt = 1'b0;
        pop          = 1'b0;

        case (state)
            IDLE: begin
                div_nxt = '0;
                sck_nxt = 1'b0;
                ws_nxt  = 1'b0;
                sd_nxt  = 1'b0;
                if (en) state_nxt = RUN;
            end
            RUN, STOP: begin
                div_nxt   = tick ? '0 : div_cnt + DIV_W'(1);
                sck_nxt   = tick ? ~sck : sck;
                state_nxt = en ? RUN : STOP;
                if (fall) begin
                    if (state == STOP && bit_cnt == LAST_BIT) begin
                        // bit_cnt stays at the last bit so the next RUN starts with a load
                        state_nxt = IDLE;
                        ws_nxt    = 1'b0;
                        sd_nxt    = 1'b0;
                    end else begin
                        if (bit_cnt == LAST_BIT) begin
                            bit_nxt      = '0;
                            pop          = (fifo_level != '0);
                            underrun_nxt = ~pop;
                            shreg_nxt    = pop ? load_word : '0;
                        end else begin
                            bit_nxt   = bit_cnt + BIT_W'(1);
                            shreg_nxt = shreg << 1;
                        end
                        sd_nxt = shreg_nxt[FRAME_W-1];
                        if (bit_nxt == WS_SET_BIT) begin
                            ws_nxt = 1'b1;
                        end else if (bit_nxt == LAST_BIT) begin
                            ws_nxt = 1'b0;
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        busy_nxt  = (state_nxt != IDLE);
        wr_nxt    = push ? wr_ptr + AW'(1) : wr_ptr;
        rd_nxt    = pop ? rd_ptr + AW'(1) : rd_ptr;
        level_nxt = fifo_level + LVL_W'(push) - LVL_W'(pop);
        ready_nxt = (level_nxt != FULL_LVL);
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state      <= IDLE;
            div_cnt    <= '0;
            bit_cnt    <= LAST_BIT;
            shreg      <= '0;
            sck        <= 1'b0;
            ws         <= 1'b0;
            sd         <= 1'b0;
            underrun   <= 1'b0;
            busy       <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            s_ready    <= 1'b1;
        end else begin
            state      <= state_nxt;
            div_cnt    <= div_nxt;
            bit_cnt    <= bit_nxt;
            shreg      <= shreg_nxt;
            sck        <= sck_nxt;
            ws         <= ws_nxt;
            sd         <= sd_nxt;
            underrun   <= underrun_nxt;
            busy       <= busy_nxt;
            wr_ptr     <= wr_nxt;
            rd_ptr     <= rd_nxt;
            fifo_level <= level_nxt;
            s_ready    <= ready_nxt;
        end
    end

    // Frame storage needs no reset; occupancy is tracked by the pointers and level
    always_ff @(posedge HCLK) begin
        if (push) mem[wr_ptr] <= s_data;
    end

endmodule

// File: tb/tb_i2s_tx.sv
// Self-checking bench for i2s_tx: random frames against a queue-based serial-stream model.
module tb_i2s_tx;

    localparam int SW = 16;
    localparam int SLW = 32;
    localparam int CD = 4;
    localparam int FD = 8;
    localparam int FW = 2 * SLW;

    logic        HCLK;
    logic        HRESETn;
    logic        en;
    logic [2*SW-1:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic        sck, ws, sd;
    logic [$clog2(FD):0] fifo_level;
    logic        underrun;
    logic        busy;

    i2s_tx #(.SAMPLE_W(SW), .SLOT_W(SLW), .CLK_DIV(CD), .FIFO_DEPTH(FD)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .en(en),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .sck(sck), .ws(ws), .sd(sd),
        .fifo_level(fifo_level), .underrun(underrun), .busy(busy)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    int n_checks = 0;
    int n_err = 0;
    int ur_cnt = 0;
    int exp_ur = 0;
    longint cyc = 0;
    longint frame_t0 = 0;

    logic [2*SW-1:0] pend[$];
    logic [2*SW-1:0] model_q[$];
    logic rdy_prev;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Serial word of one frame, MSB first, derived directly from the slot rules
    function automatic logic [FW-1:0] exp_sd(input logic [2*SW-1:0] fr);
        logic [FW-1:0] w;
        logic [SW-1:0] l, r;
        l = fr[2*SW-1:SW];
        r = fr[SW-1:0];
        w = '0;
        for (int b = 0; b < FW; b++) begin
            if (b < SW) w[FW-1-b] = l[SW-1-b];
            else if (b >= SLW && b < SLW + SW) w[FW-1-b] = r[SW-1-(b-SLW)];
        end
        return w;
    endfunction

    function automatic logic [FW-1:0] exp_ws();
        logic [FW-1:0] w;
        w = '0;
        for (int b = 0; b < FW; b++) w[FW-1-b] = (b >= SLW - 1 && b <= FW - 2);
        return w;
    endfunction

    always @(posedge HCLK) cyc++;

    always @(negedge HCLK) if (HRESETn && underrun) ur_cnt++;

    // Stream source: offers queued frames and records each accepted one in the model
    always @(negedge HCLK) begin
        if (!HRESETn) begin
            s_valid = 1'b0;
            s_data = '0;
            rdy_prev = 1'b0;
        end else begin
            if (s_valid && rdy_prev) begin
                model_q.push_back(s_data);
                void'(pend.pop_front());
            end
            s_valid = (pend.size() > 0);
            if (s_valid) s_data = pend[0];
            rdy_prev = s_ready;
        end
    end

    task automatic wait_rise(output bit ok);
        logic p;
        p = sck;
        ok = 0;
        for (int i = 0; i < 4 * CD + 4; i++) begin
            @(negedge HCLK);
            if (sck && !p) begin
                ok = 1;
                break;
            end
            p = sck;
        end
    endtask

    task automatic wait_fall(output int cnt);
        logic p;
        p = sck;
        cnt = -1;
        for (int i = 1; i <= 200; i++) begin
            @(negedge HCLK);
            if (!sck && p) begin
                cnt = i;
                break;
            end
            p = sck;
        end
    endtask

    task automatic wait_idle(output int cnt);
        cnt = 0;
        while (busy && cnt < 1000) begin
            @(negedge HCLK);
            cnt++;
        end
    endtask

    task automatic start_run(input string tag);
        int c;
        @(negedge HCLK);
        en = 1'b1;
        wait_fall(c);
        // RUN entry edge plus one full BCLK period until the first fall
        check({tag, "_first_fall"}, 64'(c), 64'(2 * CD + 1));
    endtask

    task automatic run_frame(input string tag, input int drop_bit);
        logic [2*SW-1:0] fr;
        logic [FW-1:0] sdw, wsw;
        bit ok;
        if (model_q.size() > 0) fr = model_q.pop_front();
        else begin
            fr = '0;
            exp_ur++;
        end
        sdw = '0;
        wsw = '0;
        for (int b = 0; b < FW; b++) begin
            wait_rise(ok);
            if (!ok) begin
                check({tag, "_timeout"}, 64'(0), 64'(1));
                return;
            end
            if (b == 0) frame_t0 = cyc;
            sdw[FW-1-b] = sd;
            wsw[FW-1-b] = ws;
            if (b == drop_bit) en = 1'b0;
        end
        check({tag, "_sd"}, sdw, exp_sd(fr));
        check({tag, "_ws"}, wsw, exp_ws());
        check({tag, "_underruns"}, 64'(ur_cnt), 64'(exp_ur));
    endtask

    task automatic stop_now(input string tag);
        int c;
        en = 1'b0;
        wait_idle(c);
        check({tag, "_idle_delay"}, 64'(c), 64'(CD));
        check({tag, "_idle_pins"}, {61'd0, sck, ws, sd}, 64'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c;
        bit ok;
        longint t_prev;
        int lvl;
        en = 1'b0;
        HRESETn = 1'b0;
        repeat (3) @(negedge HCLK);
        check("rst_pins", {59'd0, sck, ws, sd, underrun, busy}, 64'd0);
        check("rst_ready", 64'(s_ready), 64'd1);
        check("rst_level", 64'(fifo_level), 64'd0);
        #2 HRESETn = 1'b1;

        // Idle with en low
        repeat (20) @(negedge HCLK);
        check("idle_pins", {61'd0, sck, ws, sd}, 64'd0);
        check("idle_busy", 64'(busy), 64'd0);
        check("idle_ready", 64'(s_ready), 64'd1);
        check("idle_level", 64'(fifo_level), 64'd0);
        check("idle_underrun", 64'(ur_cnt), 64'd0);

        // Known frame
        pend.push_back(32'hA5C3_0F0F);
        repeat (4) @(negedge HCLK);
        check("one_level", 64'(fifo_level), 64'd1);
        start_run("known");
        check("known_busy", 64'(busy), 64'd1);
        check("known_level", 64'(fifo_level), 64'd0);
        run_frame("known", -1);

        // Empty FIFO: silent frames, one underrun each, 512-cycle frames
        t_prev = frame_t0;
        for (int k = 0; k < 3; k++) begin
            run_frame($sformatf("empty%0d", k), -1);
            check($sformatf("empty%0d_period", k), 64'(frame_t0 - t_prev), 64'(FW * 2 * CD));
            t_prev = frame_t0;
            check($sformatf("empty%0d_level", k), 64'(fifo_level), 64'd0);
        end
        stop_now("stop1");
        check("stop1_no_load_ur", 64'(ur_cnt), 64'(exp_ur));

        // Fill to full with a ninth frame pending
        for (int k = 0; k < FD + 1; k++) pend.push_back($urandom);
        repeat (30) @(negedge HCLK);
        check("full_ready", 64'(s_ready), 64'd0);
        check("full_level", 64'(fifo_level), 64'(FD));
        start_run("burst");
        for (int k = 0; k < FD + 1; k++) run_frame($sformatf("burst%0d", k), -1);
        run_frame("burst_drain", -1);
        stop_now("stop2");

        // Stop requested mid-frame
        for (int k = 0; k < 2; k++) pend.push_back($urandom);
        repeat (6) @(negedge HCLK);
        start_run("drop");
        run_frame("drop", 10);
        wait_idle(c);
        check("drop_idle_delay", 64'(c), 64'(CD));
        check("drop_pins", {61'd0, sck, ws, sd}, 64'd0);
        check("drop_busy", 64'(busy), 64'd0);
        check("drop_level", 64'(fifo_level), 64'd1);
        check("drop_ur", 64'(ur_cnt), 64'(exp_ur));

        // Reset in the right slot with frames queued
        for (int k = 0; k < 3; k++) pend.push_back($urandom);
        repeat (6) @(negedge HCLK);
        start_run("rst_mid");
        void'(model_q.pop_front());
        lvl = int'(fifo_level);
        check("rst_mid_level", 64'(lvl), 64'd3);
        for (int b = 1; b <= SLW + 8; b++) wait_rise(ok);
        #2 HRESETn = 1'b0;
        #1;
        check("rst_mid_pins", {59'd0, sck, ws, sd, underrun, busy}, 64'd0);
        check("rst_mid_fifo", 64'(fifo_level), 64'd0);
        check("rst_mid_ready", 64'(s_ready), 64'd1);
        model_q.delete();
        pend.delete();
        @(negedge HCLK);
        #2 HRESETn = 1'b1;
        wait_fall(c);
        check("rst_mid_first_fall", 64'(c), 64'(2 * CD + 1));
        run_frame("post_rst", -1);

        en = 1'b0;
        repeat (4) @(negedge HCLK);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
